seg7_scan_driver: RTL and testbench

- Time-multiplexed scan driver for the 4-digit common-anode 7-segment display.
- Sits directly downstream of the number-formatting stage. It takes a 16-bit hex value plus per-digit decimal-point and blank masks, and drives SEGMENT/AN one digit at a time at a fixed refresh rate.
- Inputs are shadow-latched at frame boundaries, so a value change never tears mid-frame.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/hex7seg_decode.sv | 32 +++
 rtl/seg7_scan_driver.sv | 102 ++++++++++
 tb/tb_seg7_scan_driver.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display path: active-low decode
// patterns (bit 7 = dp, held off), "all off" codes and the digit index type.
package seg7_pkg;

   localparam logic [7:0] SEG_0   = 8'hC0;
   localparam logic [7:0] SEG_1   = 8'hF9;
   localparam logic [7:0] SEG_2   = 8'hA4;
   localparam logic [7:0] SEG_3   = 8'hB0;
   localparam logic [7:0] SEG_4   = 8'h99;
   localparam logic [7:0] SEG_5   = 8'h92;
   localparam logic [7:0] SEG_6   = 8'h82;
   localparam logic [7:0] SEG_7   = 8'hF8;
   localparam logic [7:0] SEG_8   = 8'h80;
   localparam logic [7:0] SEG_9   = 8'h90;
   localparam logic [7:0] SEG_A   = 8'h88;
   localparam logic [7:0] SEG_B   = 8'h83;
   localparam logic [7:0] SEG_C   = 8'hC6;
   localparam logic [7:0] SEG_D   = 8'hA1;
   localparam logic [7:0] SEG_E   = 8'h86;
   localparam logic [7:0] SEG_F   = 8'h8E;

   localparam logic [7:0] SEG_OFF = 8'hFF;
   localparam logic [3:0] AN_OFF  = 4'hF;

   typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex nibble to active-low {g,f,e,d,c,b,a} segment pattern.
module hex7seg_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // Table lookup of the segment pattern for one hex digit.
   always_comb begin
      seg = SEG_0[6:0];
      case (nibble)
         4'h0: seg = SEG_0[6:0];
         4'h1: seg = SEG_1[6:0];
         4'h2: seg = SEG_2[6:0];
         4'h3: seg = SEG_3[6:0];
         4'h4: seg = SEG_4[6:0];
         4'h5: seg = SEG_5[6:0];
         4'h6: seg = SEG_6[6:0];
         4'h7: seg = SEG_7[6:0];
         4'h8: seg = SEG_8[6:0];
         4'h9: seg = SEG_9[6:0];
         4'hA: seg = SEG_A[6:0];
         4'hB: seg = SEG_B[6:0];
         4'hC: seg = SEG_C[6:0];
         4'hD: seg = SEG_D[6:0];
         4'hE: seg = SEG_E[6:0];
         default: seg = SEG_F[6:0];
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed scan driver for a 4-digit common-anode 7-segment display.
// Inputs are captured into shadow registers only at the end of a frame so the
// displayed number never tears. Outputs are registered, one cycle behind idx.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN: blank leading zero digits
// 3..1 (a digit with its dp set is never blanked this way; digit 0 always shows).
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] value_i,
   input  logic [3:0]  dp_i,
   input  logic [3:0]  blank_i,
   output logic [7:0]  SEGMENT,
   output logic [3:0]  AN
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic [CNT_W-1:0] cnt;
   digit_idx_t       idx;
   logic [15:0]      sh_value;
   logic [3:0]       sh_dp;
   logic [3:0]       sh_blank;
   logic             tick;
   logic             frame_end;
   logic [3:0]       nibble;
   logic [6:0]       seg_pat;
   logic [3:0]       load_blank;

   assign tick      = (cnt == CNT_W'(REFRESH_DIV - 1));
   assign frame_end = tick && (idx == 2'd3);

   // Select the shadow nibble for the digit currently being scanned.
   always_comb begin
      nibble = sh_value[3:0];
      case (idx)
         2'd0: nibble = sh_value[3:0];
         2'd1: nibble = sh_value[7:4];
         2'd2: nibble = sh_value[11:8];
         default: nibble = sh_value[15:12];
      endcase
   end

   hex7seg_decode u_decode (
      .nibble (nibble),
      .seg    (seg_pat)
   );

   // Blank mask to capture at the frame boundary, including leading-zero suppression.
   always_comb begin
      load_blank = blank_i;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if ((value_i[15:12] == 4'h0)  && !dp_i[3]) load_blank[3] = 1'b1;
      if ((value_i[15:8]  == 8'h00) && !dp_i[2]) load_blank[2] = 1'b1;
      if ((value_i[15:4]  == 12'h0) && !dp_i[1]) load_blank[1] = 1'b1;
`endif
   end

   // Prescaler and digit index: each digit stays selected for REFRESH_DIV cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         idx <= 2'd0;
      end else if (tick) begin
         cnt <= '0;
         idx <= idx + 2'd1;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Shadow registers load only on the last cycle of a frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_value <= 16'h0000;
         sh_dp    <= 4'h0;
         sh_blank <= 4'hF;
      end else if (frame_end) begin
         sh_value <= value_i;
         sh_dp    <= dp_i;
         sh_blank <= load_blank;
      end
   end

   // Registered anode and segment drive for the selected digit.
   always_ff @(posedge clk) begin
      if (rst) begin
         AN      <= AN_OFF;
         SEGMENT <= SEG_OFF;
      end else if (sh_blank[idx]) begin
         AN      <= AN_OFF;
         SEGMENT <= SEG_OFF;
      end else begin
         AN      <= ~(4'b0001 << idx);
         SEGMENT <= {~sh_dp[idx], seg_pat};
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver at REFRESH_DIV=4 (16-cycle frames).
// A frame-level reference model predicts AN/SEGMENT each cycle; scenario tasks
// add fixed expectations for the documented display sequences.
module tb_seg7_scan_driver;

   logic        clk;
   logic        rst;
   logic [15:0] value_i;
   logic [3:0]  dp_i;
   logic [3:0]  blank_i;
   logic [7:0]  SEGMENT;
   logic [3:0]  AN;

   int n_cmp = 0;
   int n_err = 0;

   seg7_scan_driver #(.REFRESH_DIV(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .value_i (value_i),
      .dp_i    (dp_i),
      .blank_i (blank_i),
      .SEGMENT (SEGMENT),
      .AN      (AN)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic [7:0] seg_lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
   logic [3:0] an_tab  [4]  = '{4'hE, 4'hD, 4'hB, 4'h7};
   logic [7:0] scan_tab [4] = '{8'h83, 8'h88, 8'hA4, 8'hF9};

   // Reference model: frame number and digit slot derived from cycles since reset.
   int unsigned tb_n;
   logic [15:0] m_val;
   logic [3:0]  m_dp, m_blank;
   logic [3:0]  exp_an;
   logic [7:0]  exp_seg;

   function automatic logic [3:0] lz_mask(input logic [15:0] v, input logic [3:0] dp);
      logic [3:0] m;
      m = 4'h0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      for (int d = 1; d < 4; d++)
         if (((v >> (4 * d)) == 16'h0) && !dp[d]) m[d] = 1'b1;
`endif
      return m;
   endfunction

   always @(posedge clk) begin
      int d;
      logic [3:0] nib;
      if (rst) begin
         tb_n    = 0;
         m_val   = 16'h0;
         m_dp    = 4'h0;
         m_blank = 4'hF;
         exp_an  = 4'hF;
         exp_seg = 8'hFF;
      end else begin
         tb_n++;
         d   = int'((tb_n - 1) / 4) % 4;
         nib = 4'(m_val >> (4 * d));
         if (m_blank[d]) begin
            exp_an  = 4'hF;
            exp_seg = 8'hFF;
         end else begin
            exp_an  = ~(4'b0001 << d);
            exp_seg = {~m_dp[d], seg_lut[nib][6:0]};
         end
         if (tb_n % 16 == 0) begin
            m_val   = value_i;
            m_dp    = dp_i;
            m_blank = blank_i | lz_mask(value_i, dp_i);
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1; value_i = 16'h0; dp_i = 4'h0; blank_i = 4'h0;
      repeat (3) @(negedge clk);
      value_i = 16'h12AB;
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         n_cmp++;
         if (AN !== 4'hF || SEGMENT !== 8'hFF) begin
            n_err++;
            $display("FAIL reset_dark cyc=%0d AN=%b SEG=%h want AN=1111 SEG=ff", i, AN, SEGMENT);
         end
         n_cmp++;
         if (AN !== exp_an || SEGMENT !== exp_seg) begin
            n_err++;
            $display("FAIL reset_model cyc=%0d AN=%b/%b SEG=%h/%h", i, AN, exp_an, SEGMENT, exp_seg);
         end
      end
   endtask

   task automatic test_scan_order();
      int d;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         d = int'((tb_n - 1) / 4) % 4;
         n_cmp++;
         if (AN !== an_tab[d] || SEGMENT !== scan_tab[d]) begin
            n_err++;
            $display("FAIL scan_order n=%0d AN=%b want %b SEG=%h want %h", tb_n, AN, an_tab[d], SEGMENT, scan_tab[d]);
         end
      end
   endtask

   task automatic test_no_tearing();
      int d;
      for (int i = 0; i < 16 && (tb_n % 16) != 6; i++) @(negedge clk);
      value_i = 16'h0000;
      for (int i = 0; i < 26; i++) begin
         @(negedge clk);
         d = int'((tb_n - 1) / 4) % 4;
         n_cmp++;
         if (AN !== exp_an || SEGMENT !== exp_seg) begin
            n_err++;
            $display("FAIL tearing_model n=%0d AN=%b/%b SEG=%h/%h", tb_n, AN, exp_an, SEGMENT, exp_seg);
         end
         if ((tb_n % 16) > 8 || (tb_n % 16) == 0) begin
            if ((tb_n - 1) / 16 == (tb_n - 1 - i) / 16 + 0 && i < 10) begin
               n_cmp++;
               if (AN !== an_tab[d] || SEGMENT !== scan_tab[d]) begin
                  n_err++;
                  $display("FAIL tearing_old n=%0d AN=%b want %b SEG=%h want %h", tb_n, AN, an_tab[d], SEGMENT, scan_tab[d]);
               end
            end
         end
`ifndef SEG7_LEADING_ZERO_BLANK_EN
         if (i >= 10) begin
            n_cmp++;
            if (AN !== an_tab[d] || SEGMENT !== 8'hC0) begin
               n_err++;
               $display("FAIL tearing_new n=%0d AN=%b want %b SEG=%h want c0", tb_n, AN, an_tab[d], SEGMENT);
            end
         end
`endif
      end
   endtask

   task automatic test_dp_blank();
      logic [3:0] an_w [4];
      logic [7:0] sg_w [4];
      int d;
      an_w = '{4'hE, 4'hD, 4'hB, 4'hF};
      sg_w = '{8'h83, 8'h88, 8'h24, 8'hFF};
      value_i = 16'h12AB; dp_i = 4'b0100; blank_i = 4'b1000;
      @(negedge clk);
      for (int i = 0; i < 16 && (tb_n % 16) != 0; i++) @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         d = int'((tb_n - 1) / 4) % 4;
         n_cmp++;
         if (AN !== an_w[d] || SEGMENT !== sg_w[d]) begin
            n_err++;
            $display("FAIL dp_blank n=%0d AN=%b want %b SEG=%h want %h", tb_n, AN, an_w[d], SEGMENT, sg_w[d]);
         end
         n_cmp++;
         if (AN !== exp_an || SEGMENT !== exp_seg) begin
            n_err++;
            $display("FAIL dp_blank_model n=%0d AN=%b/%b SEG=%h/%h", tb_n, AN, exp_an, SEGMENT, exp_seg);
         end
      end
   endtask

   task automatic test_mid_reset();
      value_i = 16'h12AB; dp_i = 4'h0; blank_i = 4'h0;
      for (int i = 0; i < 40 && (tb_n % 16) != 9; i++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (AN !== 4'hF || SEGMENT !== 8'hFF) begin
         n_err++;
         $display("FAIL mid_reset_edge AN=%b SEG=%h want AN=1111 SEG=ff", AN, SEGMENT);
      end
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_cmp++;
         if (i < 16) begin
            if (AN !== 4'hF || SEGMENT !== 8'hFF) begin
               n_err++;
               $display("FAIL mid_reset_dark cyc=%0d AN=%b SEG=%h want AN=1111 SEG=ff", i, AN, SEGMENT);
            end
         end else if (AN !== 4'hE || SEGMENT !== 8'h83) begin
            n_err++;
            $display("FAIL mid_reset_first cyc=%0d AN=%b SEG=%h want AN=1110 SEG=83", i, AN, SEGMENT);
         end
      end
   endtask

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   task automatic test_leading_zero();
      logic [15:0] vals [2];
      logic [3:0]  an_w [2][4];
      logic [7:0]  sg_w [2][4];
      int d;
      vals = '{16'h0007, 16'h0070};
      an_w = '{'{4'hE, 4'hF, 4'hF, 4'hF}, '{4'hE, 4'hD, 4'hF, 4'hF}};
      sg_w = '{'{8'hF8, 8'hFF, 8'hFF, 8'hFF}, '{8'hC0, 8'hF8, 8'hFF, 8'hFF}};
      dp_i = 4'h0; blank_i = 4'h0;
      for (int k = 0; k < 2; k++) begin
         value_i = vals[k];
         @(negedge clk);
         for (int i = 0; i < 16 && (tb_n % 16) != 0; i++) @(negedge clk);
         for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            d = int'((tb_n - 1) / 4) % 4;
            n_cmp++;
            if (AN !== an_w[k][d] || SEGMENT !== sg_w[k][d]) begin
               n_err++;
               $display("FAIL leading_zero v=%h d=%0d AN=%b want %b SEG=%h want %h", vals[k], d, AN, an_w[k][d], SEGMENT, sg_w[k][d]);
            end
         end
      end
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 1200; i++) begin
         @(negedge clk);
         n_cmp++;
         if (AN !== exp_an || SEGMENT !== exp_seg) begin
            n_err++;
            $display("FAIL random_model i=%0d n=%0d AN=%b/%b SEG=%h/%h", i, tb_n, AN, exp_an, SEGMENT, exp_seg);
         end
         rst = ($urandom_range(0, 150) == 0);
         if ($urandom_range(0, 6) == 0) begin
            value_i = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            dp_i    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            blank_i = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_scan_order();
      test_no_tearing();
      test_dp_blank();
      test_mid_reset();
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      test_leading_zero();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
